j17_control_unit: RTL and testbench
===================================

// Module: j17_control_unit
// PURPOSE
//  Multi-cycle sequencer for the J17 DATAPATH. Fetches a 32-bit instruction from instruction memory,
//  decodes it, and drives the datapath control bus (alucode, op0-op2, imControl, regenable,
//  ramenable, pcControl, writecode) for exactly one commit cycle per instruction.
//  Handles variable-latency instruction/data memory handshakes, halt, illegal-opcode and memory timeout faults.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles to wait for imem_ready/dmem_ready before fault (>=1)
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clock        in   1      processor clock, all state on posedge
//  reset_n      in   1      asynchronous active-low reset
//  run          in   1      level; start/continue execution from IDLE
//  pc           in   32     current PC from datapath
//  imem_req     out  1      instruction fetch request
//  imem_addr    out  32     fetch address (= pc)
//  imem_ready   in   1      fetch data valid this cycle
//  imem_rdata   in   32     instruction word
//  dmem_ready   in   1      data RAM access complete this cycle
//  alucode      out  5      ALU operation
//  op0/op1/op2  out  5 each destination / source1 / source2-or-imm5 fields
//  imControl    out  1      op2 is immediate
//  regenable    out  1      register write enable (commit cycle only)
//  ramenable    out  2      01 = read, 10 = write, 00 = idle
//  pcControl    out  3      PC update mode, 0 = PC+1 (sequential)
//  writecode    out  2      write-back source: 0 ALU, 1 num2, 2 memory
//  dp_commit    out  1      one-cycle strobe: datapath registers/PC update this cycle
//  halted       out  1      in HALT state
//  fault        out  2      00 none, 01 illegal opcode, 10 memory timeout (sticky)
//  retired      out  CNT_W  committed instruction count, saturating
// BEHAVIOUR
//  Instr format: [31:27] opcode, [26:22] op0, [21:17] op1, [16:12] op2, [11] imm flag, rest ignored.
//  Opcodes: 0x00-0x0B ALU (alucode=opcode, regenable, writecode 0); 0x10 MOV (regenable, writecode 1);
//   0x11 LOAD (ramenable 01, regenable, writecode 2); 0x12 STORE (ramenable 10, no reg write);
//   0x13 HALT; 0x18 NOP; 0x19-0x1F branch (pcControl=opcode[2:0], no reg write); all others illegal.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, COMMIT, HALT.
//  IDLE: wait run=1 -> FETCH. FETCH: imem_req=1, imem_addr=pc; on imem_ready latch imem_rdata -> DECODE.
//  DECODE (1 cycle): register fields; illegal -> HALT, fault=01; HALT opcode -> HALT, fault=00.
//  EXEC (1 cycle): drive op fields/imControl/alucode so datapath operands settle; LOAD/STORE -> MEM, else COMMIT.
//  MEM: hold ramenable nonzero until dmem_ready (dmem_ready in first MEM cycle accepted) -> COMMIT.
//  COMMIT (1 cycle): dp_commit=1, regenable per opcode, pcControl per opcode, retired+1 (sat at all-ones);
//   then run=1 -> FETCH, run=0 -> IDLE.
//  regenable, pcControl!=0 only valid with dp_commit; outside COMMIT regenable=0, pcControl=0, ramenable=00 except MEM.
//  Timeout: wait counter cleared on entering FETCH/MEM; reaching MEM_TIMEOUT cycles without ready -> HALT, fault=10,
//   nothing committed, PC unchanged.
//  HALT: all strobes 0, halted=1; exit only via reset_n. fault sticky until reset.
//  Latency: ALU/MOV/branch/NOP = fetch wait + 4 cycles (FETCH..COMMIT, zero-wait memory); LOAD/STORE +1 min.
//  run deassert mid-instruction: current instruction completes through COMMIT, then IDLE.
//  Reset (async, reset_n=0): state IDLE; all outputs 0 (imem_req, ramenable, regenable, dp_commit, fault, retired,
//   halted, alucode, op fields, pcControl, writecode); latched instr cleared.
// TESTING
//  1. Reset, run=1, zero-wait imem returning ADD r3,r1,r2 (0x01<<27 ...) -> dp_commit on cycle 4, regenable=1,
//     alucode=1, op0=3, writecode=0, pcControl=0, retired=1.
//  2. LOAD with dmem_ready delayed 3 cycles -> ramenable=01 held 4 MEM cycles, then COMMIT writecode=2, regenable=1.
//  3. Branch opcode 0x1A -> COMMIT pcControl=2, regenable=0; STORE -> ramenable=10, regenable=0.
//  4. Opcode 0x15 -> HALT, fault=01, halted=1, no dp_commit; later run toggles ignored until reset_n pulse.
//  5. dmem_ready never asserted, MEM_TIMEOUT=16 -> HALT after 16 MEM cycles, fault=10, retired unchanged.
//  6. reset_n low during MEM -> immediate IDLE, ramenable=00, all outputs 0; run=1 restarts with FETCH.

Source files
------------

// File: rtl/j17_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the J17 datapath.
// Drives the datapath control bus and commits exactly once per instruction.
module j17_control_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             run,
   input  logic [31:0]      pc,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   input  logic             dmem_ready,
   output logic [4:0]       alucode,
   output logic [4:0]       op0,
   output logic [4:0]       op1,
   output logic [4:0]       op2,
   output logic             imControl,
   output logic             regenable,
   output logic [1:0]       ramenable,
   output logic [2:0]       pcControl,
   output logic [1:0]       writecode,
   output logic             dp_commit,
   output logic             halted,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state_dbg
);

   // Handshake: imem_ready/dmem_ready are sampled on the posedge while the request
   // (imem_req or nonzero ramenable) is high; ready in the first request cycle is accepted.

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_COMMIT, S_HALT
   } state_t;

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   state_t         state, state_n;
   logic [31:11]   instr_q;
   logic [TW-1:0]  wait_cnt;
   logic           wr_q;
   logic [2:0]     pcc_q;
   logic [1:0]     ram_q;
   logic           timeout;

   logic           unused_low_bits;
   assign unused_low_bits = ^imem_rdata[10:0];

   logic [4:0]     opc;
   logic           d_legal, d_halt, d_alu, d_wr;
   logic [1:0]     d_wc, d_ram;
   logic [2:0]     d_pcc;

   assign opc = instr_q[31:27];

   always_comb begin
      d_legal = 1'b1;
      d_halt  = 1'b0;
      d_alu   = 1'b0;
      d_wr    = 1'b0;
      d_wc    = 2'd0;
      d_ram   = 2'b00;
      d_pcc   = 3'd0;
      if (opc <= 5'h0B) begin
         d_alu = 1'b1;
         d_wr  = 1'b1;
      end else begin
         case (opc)
            5'h10: begin d_wr = 1'b1; d_wc = 2'd1; end
            5'h11: begin d_wr = 1'b1; d_wc = 2'd2; d_ram = 2'b01; end
            5'h12: d_ram  = 2'b10;
            5'h13: d_halt = 1'b1;
            5'h18: d_legal = 1'b1;
            5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F: d_pcc = opc[2:0];
            default: d_legal = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      timeout = 1'b0;
      case (state)
         S_IDLE:   if (run) state_n = S_FETCH;
         S_FETCH: begin
            if (imem_ready) state_n = S_DECODE;
            else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
               state_n = S_HALT;
               timeout = 1'b1;
            end
         end
         S_DECODE: state_n = (!d_legal || d_halt) ? S_HALT : S_EXEC;
         S_EXEC:   state_n = (ram_q != 2'b00) ? S_MEM : S_COMMIT;
         S_MEM: begin
            if (dmem_ready) state_n = S_COMMIT;
            else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
               state_n = S_HALT;
               timeout = 1'b1;
            end
         end
         S_COMMIT: state_n = run ? S_FETCH : S_IDLE;
         S_HALT:   state_n = S_HALT;
         default:  state_n = S_IDLE;
      endcase
   end

   // Strobes are pure functions of state so nothing leaks outside COMMIT/MEM.
   always_comb begin
      imem_req  = (state == S_FETCH);
      imem_addr = (state == S_FETCH) ? pc : 32'd0;
      ramenable = (state == S_MEM) ? ram_q : 2'b00;
      dp_commit = (state == S_COMMIT);
      regenable = (state == S_COMMIT) && wr_q;
      pcControl = (state == S_COMMIT) ? pcc_q : 3'd0;
      halted    = (state == S_HALT);
      state_dbg = state;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         instr_q   <= '0;
         wait_cnt  <= '0;
         alucode   <= 5'd0;
         op0       <= 5'd0;
         op1       <= 5'd0;
         op2       <= 5'd0;
         imControl <= 1'b0;
         writecode <= 2'd0;
         wr_q      <= 1'b0;
         pcc_q     <= 3'd0;
         ram_q     <= 2'b00;
         fault     <= 2'b00;
         retired   <= '0;
      end else begin
         state <= state_n;
         if (state_n != state)
            wait_cnt <= '0;
         else if (state == S_FETCH || state == S_MEM)
            wait_cnt <= wait_cnt + TW'(1);
         if (state == S_FETCH && imem_ready)
            instr_q <= imem_rdata[31:11];
         if (state == S_DECODE) begin
            if (d_legal && !d_halt) begin
               alucode   <= d_alu ? opc : 5'd0;
               op0       <= instr_q[26:22];
               op1       <= instr_q[21:17];
               op2       <= instr_q[16:12];
               imControl <= instr_q[11];
               writecode <= d_wc;
               wr_q      <= d_wr;
               pcc_q     <= d_pcc;
               ram_q     <= d_ram;
            end else if (!d_legal) begin
               fault <= 2'b01;
            end
         end
         if (timeout)
            fault <= 2'b10;
         if (state == S_COMMIT && retired != '1)
            retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_j17_control_unit.sv
// Self-checking bench for j17_control_unit: directed table, hand-written fault
// sequences, and randomized instructions checked against a behavioural model.
module tb_j17_control_unit;

   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 4;
   localparam int BW          = 29;
   localparam int RET_MAX     = (1 << CNT_W) - 1;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             run = 1'b0;
   logic [31:0]      pc = 32'd0;
   logic             imem_ready = 1'b0;
   logic [31:0]      imem_rdata = 32'd0;
   logic             dmem_ready = 1'b0;
   logic             imem_req;
   logic [31:0]      imem_addr;
   logic [4:0]       alucode, op0, op1, op2;
   logic             imControl, regenable, dp_commit, halted;
   logic [1:0]       ramenable, writecode, fault;
   logic [2:0]       pcControl, state_dbg;
   logic [CNT_W-1:0] retired;

   j17_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset_n(reset_n), .run(run), .pc(pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .dmem_ready(dmem_ready),
      .alucode(alucode), .op0(op0), .op1(op1), .op2(op2),
      .imControl(imControl), .regenable(regenable), .ramenable(ramenable),
      .pcControl(pcControl), .writecode(writecode), .dp_commit(dp_commit),
      .halted(halted), .fault(fault), .retired(retired), .state_dbg(state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   int ret_model = 0;
   logic [BW-1:0] exp_q[$];

   typedef struct {
      bit            committed;
      bit            halted_seen;
      logic [BW-1:0] bus;
      logic [1:0]    ram;
      int            lat;
      int            mem_cyc;
      int            viol;
      int            ret_at_commit;
   } obs_t;

   typedef struct {
      bit            commit;
      bit            halt;
      logic [1:0]    fault;
      logic [BW-1:0] bus;
      int            lat;
      int            mem;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      int          iw;
      int          dw;
      bit          wr;
      logic [2:0]  pcc;
      logic [1:0]  wc;
      logic [4:0]  alu;
      logic [1:0]  ram;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
      end
   endtask

   // Behavioural model: what the spec says one instruction does given memory waits.
   function automatic exp_t predict(input logic [31:0] ins, input int iw, input int dw);
      exp_t e;
      int o;
      bit wr;
      logic [2:0] pcc;
      logic [1:0] wc, ram;
      logic [4:0] alu;
      e = '{default: 0};
      o = int'(ins[31:27]);
      wr = 0; pcc = 0; wc = 0; ram = 0; alu = 0;
      if (iw >= MEM_TIMEOUT) begin
         e.halt = 1; e.fault = 2'b10; e.lat = MEM_TIMEOUT + 1;
         return e;
      end
      if (o < 12) begin wr = 1; alu = 5'(o); end
      else if (o == 16) begin wr = 1; wc = 1; end
      else if (o == 17) begin wr = 1; wc = 2; ram = 2'b01; end
      else if (o == 18) ram = 2'b10;
      else if (o == 19) begin e.halt = 1; e.fault = 2'b00; e.lat = iw + 3; return e; end
      else if (o == 24) wr = 0;
      else if (o >= 25) pcc = 3'(o - 24);
      else begin e.halt = 1; e.fault = 2'b01; e.lat = iw + 3; return e; end
      if (ram != 0 && dw >= MEM_TIMEOUT) begin
         e.halt = 1; e.fault = 2'b10; e.mem = MEM_TIMEOUT;
         e.lat = iw + MEM_TIMEOUT + 4;
         return e;
      end
      e.commit = 1;
      e.mem = (ram != 0) ? dw + 1 : 0;
      e.lat = iw + 4 + e.mem;
      e.bus = {wr, pcc, wc, alu, ins[26:22], ins[21:17], ins[16:12], ins[11], ram};
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset_n = 1'b0;
      run = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      ret_model = 0;
   endtask

   // Plays instruction and data memory for one instruction; returns at the commit or halt cycle.
   task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                            input bit drop_run, output obs_t o);
      int fc, dc;
      bit started;
      o = '{default: 0};
      fc = 0; dc = 0; started = 0;
      imem_rdata = instr;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clock);
         if (imem_req) begin
            started = 1;
            if (imem_addr !== pc) o.viol++;
            imem_ready = (fc >= iw);
            fc++;
         end else imem_ready = 1'b0;
         if (ramenable != 2'b00) begin
            if (o.ram == 2'b00) o.ram = ramenable;
            dmem_ready = (dc >= dw);
            dc++;
         end else dmem_ready = 1'b0;
         if (started) o.lat++;
         if (!dp_commit && (regenable || pcControl != 3'd0)) o.viol++;
         if (drop_run && started && !imem_req) run = 1'b0;
         if (dp_commit) begin
            o.committed = 1;
            o.bus = {regenable, pcControl, writecode, alucode, op0, op1, op2, imControl, o.ram};
            o.ret_at_commit = int'(retired);
            break;
         end
         if (halted) begin
            o.halted_seen = 1;
            break;
         end
      end
      o.mem_cyc = dc;
   endtask

   task automatic compare(input string tag, input obs_t o, input exp_t e);
      logic [BW-1:0] want;
      check({tag, "_commit"}, 64'(o.committed), 64'(e.commit));
      check({tag, "_halt"}, 64'(o.halted_seen), 64'(e.halt));
      check({tag, "_lat"}, 64'(o.lat), 64'(e.lat));
      check({tag, "_memcyc"}, 64'(o.mem_cyc), 64'(e.mem));
      check({tag, "_strobe"}, 64'(o.viol), 64'd0);
      check({tag, "_fault"}, 64'(fault), 64'(e.fault));
      if (e.commit) begin
         want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
         check({tag, "_bus"}, 64'(o.bus), 64'(want));
         check({tag, "_retired"}, 64'(o.ret_at_commit), 64'(ret_model));
         if (ret_model != RET_MAX) ret_model++;
      end
   endtask

   // ---------------- test ----------------
   vec_t vecs[10];
   int   legal_ops[$];

   initial begin
      obs_t o;
      exp_t e;
      vecs[0] = '{32'h08C22000, 0, 0, 1'b1, 3'd0, 2'd0, 5'd1,  2'b00, 4};
      vecs[1] = '{32'h89447800, 0, 3, 1'b1, 3'd0, 2'd2, 5'd0,  2'b01, 8};
      vecs[2] = '{32'hD0060000, 2, 0, 1'b0, 3'd2, 2'd0, 5'd0,  2'b00, 6};
      vecs[3] = '{32'h90080000, 0, 0, 1'b0, 3'd0, 2'd0, 5'd0,  2'b10, 5};
      vecs[4] = '{32'h81C00800, 0, 0, 1'b1, 3'd0, 2'd1, 5'd0,  2'b00, 4};
      vecs[5] = '{32'hC0000000, 1, 0, 1'b0, 3'd0, 2'd0, 5'd0,  2'b00, 5};
      vecs[6] = '{32'h5FC1F000, 3, 0, 1'b1, 3'd0, 2'd0, 5'd11, 2'b00, 7};
      vecs[7] = '{32'hF8000000, 0, 0, 1'b0, 3'd7, 2'd0, 5'd0,  2'b00, 4};
      vecs[8] = '{32'h003E0800, 0, 0, 1'b1, 3'd0, 2'd0, 5'd0,  2'b00, 4};
      vecs[9] = '{32'h88000000, 0, 0, 1'b1, 3'd0, 2'd2, 5'd0,  2'b01, 5};
      for (int i = 0; i < 12; i++) legal_ops.push_back(i);
      legal_ops.push_back(16); legal_ops.push_back(17); legal_ops.push_back(18);
      for (int i = 24; i < 32; i++) legal_ops.push_back(i);

      // reset state
      do_reset();
      check("reset_ctrl", 64'({imem_req, alucode, op0, op1, op2, imControl, regenable, ramenable,
                               pcControl, writecode, dp_commit, halted, fault, retired}), 64'd0);
      check("reset_addr", 64'(imem_addr), 64'd0);

      // directed table
      run = 1'b1;
      foreach (vecs[i]) begin
         pc = $urandom;
         e = '{default: 0};
         e.commit = 1;
         e.lat = vecs[i].lat;
         e.mem = (vecs[i].ram != 2'b00) ? vecs[i].dw + 1 : 0;
         e.bus = {vecs[i].wr, vecs[i].pcc, vecs[i].wc, vecs[i].alu, vecs[i].instr[26:22],
                  vecs[i].instr[21:17], vecs[i].instr[16:12], vecs[i].instr[11], vecs[i].ram};
         exp_q.push_back(e.bus);
         run_instr(vecs[i].instr, vecs[i].iw, vecs[i].dw, 1'b0, o);
         compare($sformatf("vec%0d", i), o, e);
      end

      // randomized instructions against the model; retired saturates along the way
      for (int n = 0; n < 40; n++) begin
         logic [31:0] ins;
         int iw, dw;
         bit drop;
         ins = $urandom;
         ins[31:27] = 5'(legal_ops[$urandom_range(0, legal_ops.size() - 1)]);
         iw = $urandom_range(0, 4);
         dw = $urandom_range(0, 5);
         drop = ($urandom_range(0, 3) == 0);
         pc = $urandom;
         e = predict(ins, iw, dw);
         if (e.commit) exp_q.push_back(e.bus);
         run_instr(ins, iw, dw, drop, o);
         compare($sformatf("rnd%0d", n), o, e);
         if (drop) begin
            @(negedge clock);
            check($sformatf("rnd%0d_idle", n), 64'(imem_req), 64'd0);
            run = 1'b1;
         end
      end
      check("retired_saturated", 64'(retired), 64'(RET_MAX));

      // illegal opcode: halt with fault 01, run toggles ignored
      run_instr(32'hA8000000, 1, 0, 1'b0, o);
      compare("illegal", o, predict(32'hA8000000, 1, 0));
      for (int i = 0; i < 6; i++) begin
         run = 1'($urandom_range(0, 1));
         @(negedge clock);
         check($sformatf("halt_hold%0d", i), 64'({halted, imem_req, dp_commit, fault}), 64'b10001);
      end
      check("illegal_retired", 64'(retired), 64'(RET_MAX));

      // HALT opcode: halted, no fault
      do_reset();
      run = 1'b1;
      run_instr(32'h98000000, 0, 0, 1'b0, o);
      compare("haltop", o, predict(32'h98000000, 0, 0));

      // data memory never ready
      do_reset();
      run = 1'b1;
      run_instr(32'h88000000, 0, 1000, 1'b0, o);
      compare("dmem_to", o, predict(32'h88000000, 0, 1000));
      check("dmem_to_retired", 64'(retired), 64'd0);

      // instruction memory never ready
      do_reset();
      run = 1'b1;
      run_instr(32'h08C22000, 1000, 0, 1'b0, o);
      compare("imem_to", o, predict(32'h08C22000, 1000, 0));

      // asynchronous reset in the middle of a MEM wait
      do_reset();
      run = 1'b1;
      imem_rdata = 32'h88000000;
      begin
         int mc;
         mc = 0;
         for (int c = 0; c < 60 && mc < 3; c++) begin
            @(negedge clock);
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            if (ramenable != 2'b00) mc++;
         end
         check("rst_mem_reached", 64'(mc), 64'd3);
         check("rst_mem_ram", 64'(ramenable), 64'b01);
      end
      #2 reset_n = 1'b0;
      #1;
      check("rst_async_ctrl", 64'({imem_req, alucode, op0, op1, op2, imControl, regenable, ramenable,
                                   pcControl, writecode, dp_commit, halted, fault, retired}), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      ret_model = 0;
      e = predict(32'hC0000000, 0, 0);
      exp_q.push_back(e.bus);
      run_instr(32'hC0000000, 0, 0, 1'b0, o);
      compare("after_rst", o, e);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
